// File: rtl/clz_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : clz_share_arbiter (+ count_leading_zeros_32)
// Brief    : Round-robin arbiter sharing one 32-bit leading-zero counter
//            among N_REQ requesters, with a one-entry response register.
// Revision : 1.0 - initial release
// ============================================================================

module count_leading_zeros_32 (
    input  logic [31:0] i_word,
    output logic [4:0]  o_count,
    output logic        o_all_zeros
);

    // Scanning upward lets the most significant set bit win the final write.
    always_comb begin
        o_count     = 5'd0;
        o_all_zeros = (i_word == 32'd0);
        for (int b = 0; b < 32; b++) begin
            if (i_word[b]) begin
                o_count = 5'(31 - b);
            end
        end
    end

endmodule

module clz_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_N,
    input  logic [N_REQ-1:0]      i_REQ_VALID,
    input  logic [32*N_REQ-1:0]   i_REQ_WORD,
    output logic [N_REQ-1:0]      o_REQ_READY,
    output logic                  o_RSP_VALID,
    input  logic                  i_RSP_READY,
    output logic [ID_W-1:0]       o_RSP_ID,
    output logic [4:0]            o_RSP_ZERO_COUNT,
    output logic                  o_RSP_ALL_ZEROS
);

    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;

    logic [0:0]      r_state;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_rsp_id;
    logic [4:0]      r_rsp_count;
    logic            r_rsp_all_zeros;

    logic            w_can_accept;
    logic            w_grant_valid;
    logic            w_accept;
    logic [ID_W-1:0] w_grant_id;
    logic [ID_W-1:0] w_ptr_next;
    logic [31:0]     w_grant_word;
    logic [4:0]      w_clz_count;
    logic            w_clz_all_zeros;

    function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return ID_W'(sum);
    endfunction

    // Walk offsets from farthest to nearest so the requester closest to the
    // pointer is the last (winning) assignment.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (i_REQ_VALID[f_wrap(r_ptr, off)]) begin
                w_grant_valid = 1'b1;
                w_grant_id    = f_wrap(r_ptr, off);
            end
        end
    end

    assign w_can_accept = (r_state == c_EMPTY) || i_RSP_READY;
    // Gating with reset keeps ready low while the register is held in reset.
    assign w_accept     = i_RST_N && w_can_accept && w_grant_valid;
    assign w_grant_word = i_REQ_WORD[{w_grant_id, 5'd0} +: 32];
    assign w_ptr_next   = (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);

    for (genvar k = 0; k < N_REQ; k++) begin : g_ready
        assign o_REQ_READY[k] = w_accept && (w_grant_id == ID_W'(k));
    end

    count_leading_zeros_32 u_clz (
        .i_word      (w_grant_word),
        .o_count     (w_clz_count),
        .o_all_zeros (w_clz_all_zeros)
    );

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_state         <= c_EMPTY;
            r_ptr           <= '0;
            r_rsp_id        <= '0;
            r_rsp_count     <= 5'd0;
            r_rsp_all_zeros <= 1'b0;
        end else begin
            if (w_accept) begin
                r_state         <= c_FULL;
                r_ptr           <= w_ptr_next;
                r_rsp_id        <= w_grant_id;
                r_rsp_count     <= w_clz_count;
                r_rsp_all_zeros <= w_clz_all_zeros;
            end else if ((r_state == c_FULL) && i_RSP_READY) begin
                r_state <= c_EMPTY;
            end
        end
    end

    assign o_RSP_VALID      = (r_state == c_FULL);
    assign o_RSP_ID         = r_rsp_id;
    assign o_RSP_ZERO_COUNT = r_rsp_count;
    assign o_RSP_ALL_ZEROS  = r_rsp_all_zeros;

endmodule

`default_nettype wire

// File: doc/clz_share_arbiter.md
CLZ_SHARE_ARBITER -- requirements
Module: clz_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one 32-bit leading-zero counter; legal values 2..8.
REQ-002 Parameter ID_W, default 2: requester ID width, equal to clog2(N_REQ).
REQ-003 i_CLK  input  1  single clock; every register in the block is rising-edge triggered on it.
REQ-004 i_RST_N  input  1  reset; asynchronous assert, active-low.
REQ-005 i_REQ_VALID  input  N_REQ  bit k set: requester k offers a word.
REQ-006 i_REQ_WORD  input  32*N_REQ  requester k word at bits [32k+31:32k].
REQ-007 o_REQ_READY  output  N_REQ  one-hot or zero; bit k set: requester k's word is accepted this cycle.
REQ-008 o_RSP_VALID  output  1  the response register holds a result.
REQ-009 i_RSP_READY  input  1  the consumer accepts the response this cycle.
REQ-010 o_RSP_ID  output  ID_W  index of the requester whose word produced the response.
REQ-011 o_RSP_ZERO_COUNT  output  5  leading-zero count of the accepted word.
REQ-012 o_RSP_ALL_ZEROS  output  1  the accepted word was 32'd0.

Function
REQ-013 The block SHALL contain exactly one instance of count_leading_zeros_32, fed combinationally by the word of the currently granted requester.
REQ-014 The block SHALL implement a two-state FSM: EMPTY (o_RSP_VALID=0) and FULL (o_RSP_VALID=1).
REQ-015 "Can accept" SHALL be true in EMPTY, and in FULL when i_RSP_READY=1.
REQ-016 Grant SHALL be round-robin: starting from pointer P, pick the first k in P, P+1, ... (mod N_REQ) with i_REQ_VALID[k]=1.
REQ-017 o_REQ_READY[k] SHALL be 1 only when "can accept" is true and k is the granted requester; otherwise all bits SHALL be 0.
REQ-018 On accept of requester k, P SHALL become (k+1) mod N_REQ; P SHALL be unchanged in cycles with no accept.
REQ-019 On accept, the response register SHALL load the ID, count and all-zeros flag in the same edge; results SHALL appear one cycle after the handshake (latency 1).
REQ-020 FSM transitions SHALL be:
- EMPTY with accept -> FULL.
- FULL with i_RSP_READY=1 and accept -> FULL, loading the new result (back-to-back, one result per cycle).
- FULL with i_RSP_READY=1 and no accept -> EMPTY.
- FULL with i_RSP_READY=0 -> FULL, all response outputs held bit-stable.
REQ-021 For an all-zero word, o_RSP_ALL_ZEROS SHALL be 1 and o_RSP_ZERO_COUNT SHALL be forced to 5'd0.
REQ-022 For a nonzero word, o_RSP_ZERO_COUNT SHALL equal the number of leading zeros (0..31), and o_RSP_ALL_ZEROS SHALL be 0.
REQ-023 o_REQ_READY SHALL depend only on i_REQ_VALID, P, state and i_RSP_READY, never on i_REQ_WORD.
REQ-024 A requester that holds i_REQ_VALID=1 SHALL be granted within N_REQ accepts (no starvation).
REQ-025 A requester deasserting valid before being granted SHALL NOT be accepted, and P SHALL NOT be affected.

Reset
REQ-026 While i_RST_N=0, the block SHALL hold: state EMPTY, o_RSP_VALID=0, o_RSP_ID=0, o_RSP_ZERO_COUNT=0, o_RSP_ALL_ZEROS=0, P=0, o_REQ_READY=0.
REQ-027 A reset asserted with a response held in FULL SHALL discard that response immediately, with no handshake completed in that cycle.
REQ-028 The first accept after reset release SHALL occur no earlier than the first rising edge with i_RST_N=1.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Single request: requester 2 offers 32'h0000_8000 while EMPTY -> o_REQ_READY=4'b0100; next cycle o_RSP_VALID=1, ID=2, count=16, ALL_ZEROS=0.
- All-zero and MSB words: requester 0 offers 32'h0 -> count=0, ALL_ZEROS=1; then 32'h8000_0000 -> count=0, ALL_ZEROS=0; then 32'h1 -> count=31.
- Round-robin: all 4 valid continuously with i_RSP_READY=1 -> grants 0,1,2,3,0,... one per cycle, o_RSP_VALID stays 1 throughout.
- Backpressure: i_RSP_READY=0 for 5 cycles while FULL -> o_REQ_READY=0 and response outputs unchanged; on release, the new grant goes to requester P.
- Reset mid-operation: assert i_RST_N=0 while FULL with i_RSP_READY=0 -> o_RSP_VALID=0 asynchronously; after release, the first grant goes to requester 0.
- Random: constrained-random valid/ready traffic against a reference leading-zero model -> every response matches its word and ID, with no lost or duplicated words.
